// File: rtl/alu32_issue_ctrl_if.sv
// Command / ALU / result bundle for alu32_issue_ctrl.
// slave = the issue controller's view, master = the surrounding environment.
interface alu32_issue_ctrl_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_opcode;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;

  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_opcode;
  logic             alu_enable;
  logic [63:0]      alu_result;

  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_neg;
  logic [CNT_W-1:0] ops_done;

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_tag,
    input  alu_result,
    input  out_ready,
    output in_ready,
    output alu_a, alu_b, alu_opcode, alu_enable,
    output out_valid, out_result, out_tag, out_zero, out_neg, ops_done
  );

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_tag,
    output alu_result,
    output out_ready,
    input  in_ready,
    input  alu_a, alu_b, alu_opcode, alu_enable,
    input  out_valid, out_result, out_tag, out_zero, out_neg, ops_done
  );
endinterface

// File: rtl/alu32_issue_ctrl.sv
// Issue/capture stage in front of alu32: IDLE -> EXEC -> DONE, one result per 2 cycles peak.
// Define ALU_ISSUE_FLAGS_EN to build the registered out_zero/out_neg flags; otherwise they are tied low.
module alu32_issue_ctrl #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  alu32_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             in_ready_c;
  logic             accept;
  logic             out_fire;

  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic [2:0]       alu_op_q;
  logic [TAG_W-1:0] tag_q;
  logic [63:0]      result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [CNT_W-1:0] ops_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DONE accepts a new command only on the same edge its result is consumed.
  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = DONE;
      DONE: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready) state_nxt = bus.in_valid ? EXEC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = bus.in_valid && in_ready_c;
  assign out_fire = (state == DONE) && bus.out_ready;

  // Pending tag is separate from out_tag so a back-to-back accept cannot disturb the presented result.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      tag_q    <= '0;
    end else if (accept) begin
      alu_a_q  <= bus.in_a;
      alu_b_q  <= bus.in_b;
      alu_op_q <= bus.in_opcode;
      tag_q    <= bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      out_tag_q <= '0;
    end else if (state == EXEC) begin
      result_q  <= bus.alu_result;
      out_tag_q <= tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           ops_q <= '0;
    else if (out_fire) ops_q <= ops_q + 1'b1;
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic zero_q;
  logic neg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state == EXEC) begin
      zero_q <= (bus.alu_result == '0);
      neg_q  <= bus.alu_result[63];
    end
  end

  assign bus.out_zero = zero_q;
  assign bus.out_neg  = neg_q;
`else
  assign bus.out_zero = 1'b0;
  assign bus.out_neg  = 1'b0;
`endif

  assign bus.in_ready   = in_ready_c;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_enable = (state == EXEC);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.ops_done   = ops_q;

endmodule

// File: tb/tb_alu32_issue_ctrl.sv
// Directed bench for alu32_issue_ctrl with a stand-in ALU and a result/tag scoreboard.
// CNT_W is reduced to 8 so the ops_done wrap is reachable in a short run.
module tb_alu32_issue_ctrl;

  localparam int TAG_W = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;

  alu32_issue_ctrl_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  alu32_issue_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: 0 add, 1 sub, 2 mul, 3 not A, 4 and, 5 or, 6 xor, 7 pass A.
  function automatic logic [63:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa;
    logic [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd0:    return sa + sb;
      3'd1:    return sa - sb;
      3'd2:    return sa * sb;
      3'd3:    return ~sa;
      3'd4:    return {32'd0, a & b};
      3'd5:    return {32'd0, a | b};
      3'd6:    return {32'd0, a ^ b};
      default: return {32'd0, a};
    endcase
  endfunction

  // Garbage outside EXEC so a mistimed capture is visible.
  assign bus.alu_result = bus.alu_enable ? alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b)
                                         : 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct packed {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    logic             z;
    logic             n;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   exp_ops = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag);
    exp_t e;
    e.res = alu_ref(op, a, b);
    e.tag = tag;
`ifdef ALU_ISSUE_FLAGS_EN
    e.z = (e.res == 64'd0);
    e.n = e.res[63];
`else
    e.z = 1'b0;
    e.n = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_result"}, bus.out_result, e.res);
      chk({name, "_tag"}, 64'(bus.out_tag), 64'(e.tag));
      chk({name, "_zero"}, 64'(bus.out_zero), 64'(e.z));
      chk({name, "_neg"}, 64'(bus.out_neg), 64'(e.n));
    end
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
  endtask

  // Issue one command from IDLE with out_ready=1 and consume its result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
    int waited;
    drive_cmd(op, a, b, tag);
    push_exp(op, a, b, tag);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.out_valid && waited < 8);
    if (!bus.out_valid) begin
      chk("run_op_timeout", 64'(bus.out_valid), 64'd1);
      void'(sb.pop_front());
    end else begin
      sb_check("run_op");
    end
    @(posedge clk); #1;
    exp_ops++;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_alu_enable", 64'(bus.alu_enable), 64'd0);
    chk("rst_ops_done", 64'(bus.ops_done), 64'd0);
    chk("rst_out_result", bus.out_result, 64'd0);

    // ADD, latency
    bus.out_ready = 1'b1;
    drive_cmd(3'd0, 32'd5, 32'd7, 4'd3);
    push_exp(3'd0, 32'd5, 32'd7, 4'd3);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("add_alu_enable", 64'(bus.alu_enable), 64'd1);
    chk("add_alu_a", 64'(bus.alu_a), 64'd5);
    chk("add_alu_b", 64'(bus.alu_b), 64'd7);
    chk("add_in_ready_exec", 64'(bus.in_ready), 64'd0);
    chk("add_out_valid_exec", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("add_out_valid", 64'(bus.out_valid), 64'd1);
    chk("add_alu_enable_done", 64'(bus.alu_enable), 64'd0);
    chk("add_result_const", bus.out_result, 64'd12);
    sb_check("add");
    @(posedge clk); #1;
    exp_ops++;
    @(negedge clk);
    chk("add_ops_done", 64'(bus.ops_done), 64'(exp_ops));
    chk("add_back_idle", 64'(bus.in_ready), 64'd1);

    // Backpressure, with a waiting command that must not be taken early
    bus.out_ready = 1'b0;
    drive_cmd(3'd1, 32'd3, 32'd5, 4'd5);
    push_exp(3'd1, 32'd3, 32'd5, 4'd5);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    sb_check("bp");
    drive_cmd(3'd3, 32'd0, 32'd0, 4'd9);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_result", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("bp_hold_tag", 64'(bus.out_tag), 64'd5);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_alu_enable", 64'(bus.alu_enable), 64'd0);
      chk("bp_alu_a_held", 64'(bus.alu_a), 64'd3);
      chk("bp_ops_held", 64'(bus.ops_done), 64'(exp_ops));
    end

    // Back-to-back: release and accept on the same edge
    bus.out_ready = 1'b1;
    push_exp(3'd3, 32'd0, 32'd0, 4'd9);
    #1;
    chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    exp_ops++;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_ops_done", 64'(bus.ops_done), 64'(exp_ops));
    chk("b2b_alu_enable", 64'(bus.alu_enable), 64'd1);
    chk("b2b_alu_opcode", 64'(bus.alu_opcode), 64'd3);
    chk("b2b_alu_a", 64'(bus.alu_a), 64'd0);
    chk("b2b_out_valid_exec", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("b2b_out_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b_result_const", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef ALU_ISSUE_FLAGS_EN
    chk("b2b_neg_const", 64'(bus.out_neg), 64'd1);
`else
    chk("b2b_neg_const", 64'(bus.out_neg), 64'd0);
`endif
    sb_check("b2b");
    @(posedge clk); #1;
    exp_ops++;
    @(negedge clk);
    chk("b2b_ops_after", 64'(bus.ops_done), 64'(exp_ops));

    // Reset during EXEC discards the command
    drive_cmd(3'd2, 32'd6, 32'd7, 4'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rmid_in_exec", 64'(bus.alu_enable), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ops = 0;
    @(negedge clk);
    chk("rmid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rmid_ops_done", 64'(bus.ops_done), 64'd0);
    chk("rmid_alu_enable", 64'(bus.alu_enable), 64'd0);
    chk("rmid_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rmid_out_result", bus.out_result, 64'd0);
    chk("rmid_alu_a", 64'(bus.alu_a), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rmid_no_output", 64'(bus.out_valid), 64'd0);
    end

    // Random ops up to the counter's top value, then a zero result wraps it
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 4'($urandom));
    end
    @(negedge clk);
    chk("wrap_ops_max", 64'(bus.ops_done), 64'((1 << CNT_W) - 1));
    run_op(3'd4, 32'd0, $urandom, 4'd6);
    @(negedge clk);
    chk("wrap_ops_zero", 64'(bus.ops_done), 64'd0);
    chk("flag_result_zero", bus.out_result, 64'd0);
`ifdef ALU_ISSUE_FLAGS_EN
    chk("flag_zero_const", 64'(bus.out_zero), 64'd1);
`else
    chk("flag_zero_const", 64'(bus.out_zero), 64'd0);
`endif
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
